// File: rtl/exec_bpred_pkg.sv
// Shared encodings for the execute-stage ALU and the 2-bit branch predictor.
package exec_bpred_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // R-type funct[3:0] encodings recognised by the ALU-control decoder.
  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0010;
  localparam logic [3:0] FN_AND = 4'b0100;
  localparam logic [3:0] FN_OR  = 4'b0101;
  localparam logic [3:0] FN_XOR = 4'b0110;
  localparam logic [3:0] FN_NOR = 4'b0111;
  localparam logic [3:0] FN_SLT = 4'b1010;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100,
    ALU_XOR = 4'b1101
  } aluctl_e;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST)  ? CTR_ST  : ctr + 2'd1;
    else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/exec_bpred_unit_bpred_table.sv
// Direct-mapped branch target table with a 2-bit saturating counter per entry;
// combinational read-before-write lookup, clocked allocate/train updates.
module bpred_table
  import exec_bpred_pkg::*;
#(
  parameter int N_ENTRIES = 16,
  parameter int IDX_W     = $clog2(N_ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] lk_pc4,
  output logic        hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic [31:0] upd_pc4,
  input  logic        upd_wrt,
  input  logic        upd_wrp,
  input  logic [31:0] upd_target,
  input  logic        upd_taken
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic              valid  [N_ENTRIES];
  logic [TAG_W-1:0]  tag    [N_ENTRIES];
  logic [31:0]       target [N_ENTRIES];
  logic [1:0]        ctr    [N_ENTRIES];

  logic [IDX_W-1:0]  lk_idx, upd_idx;
  logic [TAG_W-1:0]  lk_tag, upd_tag;

  assign lk_idx  = lk_pc4[IDX_W+1:2];
  assign lk_tag  = lk_pc4[31:IDX_W+2];
  assign upd_idx = upd_pc4[IDX_W+1:2];
  assign upd_tag = upd_pc4[31:IDX_W+2];

  assign hit         = valid[lk_idx] && (tag[lk_idx] == lk_tag);
  assign pred_taken  = hit && ctr[lk_idx][1];
  assign pred_target = hit ? target[lk_idx] : 32'd0;

  // NOTE: the table lives in flops, not RAM, so it can be cleared asynchronously;
  // reset must wipe all history, and valid going low makes hit drop immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        valid[i]  <= 1'b0;
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= CTR_WNT;
      end
    end else if (upd_wrt) begin
      // NOTE: non-blocking writes keep this cycle's lookup reading the old entry.
      valid[upd_idx]  <= 1'b1;
      tag[upd_idx]    <= upd_tag;
      target[upd_idx] <= upd_target;
      ctr[upd_idx]    <= upd_taken ? CTR_WT : CTR_WNT;
    end else if (upd_wrp && valid[upd_idx] && (tag[upd_idx] == upd_tag)) begin
      ctr[upd_idx] <= ctr_step(ctr[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/exec_bpred_unit.sv
// Execute-side datapath: ALU-control decode, 32-bit ALU and the branch predictor table.
module exec_bpred_unit
  import exec_bpred_pkg::*;
#(
  parameter int N_ENTRIES = 16,
  parameter int IDX_W     = $clog2(N_ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  aluop,
  input  logic [5:0]  funct,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  output logic [3:0]  aluctl,
  output logic [31:0] alu_out,
  output logic        alu_zero,
  input  logic [31:0] lk_pc4,
  output logic        hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic [31:0] upd_pc4,
  input  logic        upd_wrt,
  input  logic        upd_wrp,
  input  logic [31:0] upd_target,
  input  logic        upd_taken
);

  always_comb begin
    // NOTE: default first so every path assigns aluctl and no latch is inferred.
    aluctl = ALU_ADD;
    unique case (aluop)
      ALUOP_ADD:   aluctl = ALU_ADD;
      ALUOP_SUB:   aluctl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct[3:0])
          FN_ADD:  aluctl = ALU_ADD;
          FN_SUB:  aluctl = ALU_SUB;
          FN_AND:  aluctl = ALU_AND;
          FN_OR:   aluctl = ALU_OR;
          FN_XOR:  aluctl = ALU_XOR;
          FN_NOR:  aluctl = ALU_NOR;
          FN_SLT:  aluctl = ALU_SLT;
          default: aluctl = ALU_AND;
        endcase
      end
      default:     aluctl = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_out = '0;
    case (aluctl)
      ALU_AND: alu_out = alu_a & alu_b;
      ALU_OR:  alu_out = alu_a | alu_b;
      ALU_ADD: alu_out = alu_a + alu_b;
      ALU_SUB: alu_out = alu_a - alu_b;
      ALU_SLT: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
      ALU_NOR: alu_out = ~(alu_a | alu_b);
      ALU_XOR: alu_out = alu_a ^ alu_b;
      default: alu_out = '0;
    endcase
  end

  assign alu_zero = (alu_out == 32'd0);

  bpred_table #(.N_ENTRIES(N_ENTRIES), .IDX_W(IDX_W)) u_table (
    .clk         (clk),
    .rst_n       (rst_n),
    .lk_pc4      (lk_pc4),
    .hit         (hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_pc4     (upd_pc4),
    .upd_wrt     (upd_wrt),
    .upd_wrp     (upd_wrp),
    .upd_target  (upd_target),
    .upd_taken   (upd_taken)
  );

endmodule

// File: tb/tb_exec_bpred_unit.sv
// Directed bench for exec_bpred_unit: table-driven ALU vectors plus predictor sequences.
module tb_exec_bpred_unit;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  aluctl;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic [31:0] lk_pc4;
  logic        hit, pred_taken;
  logic [31:0] pred_target;
  logic [31:0] upd_pc4, upd_target;
  logic        upd_wrt, upd_wrp, upd_taken;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exec_bpred_unit #(.N_ENTRIES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .aluop(aluop), .funct(funct), .alu_a(alu_a), .alu_b(alu_b),
    .aluctl(aluctl), .alu_out(alu_out), .alu_zero(alu_zero),
    .lk_pc4(lk_pc4), .hit(hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_pc4(upd_pc4), .upd_wrt(upd_wrt), .upd_wrp(upd_wrp),
    .upd_target(upd_target), .upd_taken(upd_taken)
  );

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  exp_ctl;
    logic [31:0] exp_out;
    logic        exp_zero;
  } alu_vec_t;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic check_lookup(input string name, input logic [31:0] pc4,
                              input logic e_hit, input logic e_taken, input logic [31:0] e_tgt);
    lk_pc4 = pc4;
    #1;
    check({name, ".hit"},    {31'd0, hit},        {31'd0, e_hit});
    check({name, ".taken"},  {31'd0, pred_taken}, {31'd0, e_taken});
    check({name, ".target"}, pred_target,         e_tgt);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [31:0] pc4, input logic [31:0] tgt, input logic taken);
    upd_pc4 = pc4; upd_target = tgt; upd_taken = taken; upd_wrt = 1'b1;
    step();
    upd_wrt = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc4, input logic taken);
    upd_pc4 = pc4; upd_taken = taken; upd_wrp = 1'b1;
    step();
    upd_wrp = 1'b0;
  endtask

  alu_vec_t vecs[14];

  initial begin
    vecs[0]  = '{2'b10, 6'b100010, 32'd5,        32'd7,        4'b0110, 32'hFFFF_FFFE, 1'b0};
    vecs[1]  = '{2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1,        4'b0111, 32'd1,         1'b0};
    vecs[2]  = '{2'b10, 6'b100000, 32'hFFFF_FFFF, 32'd1,        4'b0010, 32'd0,         1'b1};
    vecs[3]  = '{2'b10, 6'b100111, 32'd0,        32'd0,        4'b1100, 32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{2'b10, 6'b100110, 32'hFFFF_FFFF, 32'd1,        4'b1101, 32'hFFFF_FFFE, 1'b0};
    vecs[5]  = '{2'b10, 6'b001111, 32'hFFFF_FFFF, 32'd1,        4'b0000, 32'd1,         1'b0};
    vecs[6]  = '{2'b11, 6'b100010, 32'hFFFF_FFFF, 32'd1,        4'b0010, 32'd0,         1'b1};
    vecs[7]  = '{2'b00, 6'b100111, 32'd3,        32'd4,        4'b0010, 32'd7,         1'b0};
    vecs[8]  = '{2'b01, 6'b100000, 32'd3,        32'd4,        4'b0110, 32'hFFFF_FFFF, 1'b0};
    vecs[9]  = '{2'b10, 6'b100100, 32'h0000_F0F0, 32'h0000_FF00, 4'b0000, 32'h0000_F000, 1'b0};
    vecs[10] = '{2'b10, 6'b100101, 32'h0000_F0F0, 32'h0000_FF00, 4'b0001, 32'h0000_FFF0, 1'b0};
    vecs[11] = '{2'b10, 6'b101010, 32'd1,        32'hFFFF_FFFF, 4'b0111, 32'd0,         1'b1};
    vecs[12] = '{2'b10, 6'b100010, 32'd9,        32'd9,        4'b0110, 32'd0,         1'b1};
    vecs[13] = '{2'b10, 6'b101011, 32'h0000_00FF, 32'h0000_000F, 4'b0000, 32'h0000_000F, 1'b0};

    rst_n = 1'b0;
    aluop = 2'b00; funct = '0; alu_a = '0; alu_b = '0;
    lk_pc4 = 32'h0000_1234;
    upd_pc4 = '0; upd_target = '0; upd_wrt = 1'b0; upd_wrp = 1'b0; upd_taken = 1'b0;

    // Updates presented while in reset must be dropped.
    upd_pc4 = 32'h30; upd_target = 32'h99; upd_taken = 1'b1; upd_wrt = 1'b1;
    step();
    check_lookup("reset_lookup", 32'h0000_1234, 1'b0, 1'b0, 32'd0);
    upd_wrt = 1'b0;
    rst_n = 1'b1;
    step();
    check_lookup("reset_upd_ignored", 32'h30, 1'b0, 1'b0, 32'd0);

    for (int i = 0; i < 14; i++) begin
      aluop = vecs[i].op; funct = vecs[i].fn; alu_a = vecs[i].a; alu_b = vecs[i].b;
      #1;
      check($sformatf("alu%0d.ctl", i),  {28'd0, aluctl},   {28'd0, vecs[i].exp_ctl});
      check($sformatf("alu%0d.out", i),  alu_out,            vecs[i].exp_out);
      check($sformatf("alu%0d.zero", i), {31'd0, alu_zero},  {31'd0, vecs[i].exp_zero});
    end

    // Allocation: invisible in the same cycle, visible after the edge.
    upd_pc4 = 32'h14; upd_target = 32'h40; upd_taken = 1'b1; upd_wrt = 1'b1;
    check_lookup("alloc_same_cycle", 32'h14, 1'b0, 1'b0, 32'd0);
    step();
    upd_wrt = 1'b0;
    check_lookup("alloc_next", 32'h14, 1'b1, 1'b1, 32'h40);

    // Saturation up: 10 -> 11 -> 11 -> 11.
    for (int i = 0; i < 3; i++) begin
      train(32'h14, 1'b1);
      check_lookup($sformatf("sat_up%0d", i), 32'h14, 1'b1, 1'b1, 32'h40);
    end
    train(32'h14, 1'b0);
    check_lookup("nt1", 32'h14, 1'b1, 1'b1, 32'h40);
    train(32'h14, 1'b0);
    check_lookup("nt2", 32'h14, 1'b1, 1'b0, 32'h40);
    for (int i = 0; i < 3; i++) begin
      train(32'h14, 1'b0);
      check_lookup($sformatf("sat_dn%0d", i), 32'h14, 1'b1, 1'b0, 32'h40);
    end
    // Floor reached 00: two takens needed to predict taken again.
    train(32'h14, 1'b1);
    check_lookup("floor_t1", 32'h14, 1'b1, 1'b0, 32'h40);
    train(32'h14, 1'b1);
    check_lookup("floor_t2", 32'h14, 1'b1, 1'b1, 32'h40);
    train(32'h14, 1'b0);
    check_lookup("back_wnt", 32'h14, 1'b1, 1'b0, 32'h40);

    // Alias at the same index: miss, and training the alias leaves the entry alone.
    check_lookup("alias_miss", 32'h14 + 4 * N, 1'b0, 1'b0, 32'd0);
    train(32'h14 + 4 * N, 1'b1);
    check_lookup("alias_keep", 32'h14, 1'b1, 1'b0, 32'h40);
    // Training an index that was never allocated stays invalid.
    train(32'h20, 1'b1);
    check_lookup("wrp_invalid", 32'h20, 1'b0, 1'b0, 32'd0);

    // Write wins over train in the same cycle: ctr must be 10, not 11.
    upd_wrp = 1'b1;
    alloc(32'h18, 32'h80, 1'b1);
    upd_wrp = 1'b0;
    check_lookup("wrt_prec", 32'h18, 1'b1, 1'b1, 32'h80);
    train(32'h18, 1'b0);
    check_lookup("wrt_prec_nt", 32'h18, 1'b1, 1'b0, 32'h80);

    // Alias replacement via upd_wrt.
    alloc(32'h14 + 4 * N, 32'h200, 1'b0);
    check_lookup("replace_new", 32'h14 + 4 * N, 1'b1, 1'b0, 32'h200);
    check_lookup("replace_old", 32'h14, 1'b0, 1'b0, 32'd0);

    // Asynchronous reset between edges.
    alloc(32'h14, 32'h40, 1'b1);
    check_lookup("pre_reset", 32'h14, 1'b1, 1'b1, 32'h40);
    @(negedge clk);
    rst_n = 1'b0;
    check_lookup("async_reset", 32'h14, 1'b0, 1'b0, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check_lookup("post_reset_14", 32'h14, 1'b0, 1'b0, 32'd0);
    check_lookup("post_reset_18", 32'h18, 1'b0, 1'b0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
